// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a single outstanding imem request,
// a one-entry skid buffer for responses that arrive while decode is stalled,
// and redirect (taken branch/jump) handling that drops in-flight responses.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   NOP_INSTR   instruction word presented while the IF/ID slot is empty
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   imem_req/imem_addr  fetch request; address held until the matching rvalid
//   imem_rvalid/rdata   fetch response strobe and instruction word
//   stall               decode cannot accept; IF/ID contents are held
//   redirect/redirect_pc flush and refetch from redirect_pc (bits [1:0] = 0)
//   id_valid/instr/pc   IF/ID pipeline register
//   opcode/f3/f7        fields of id_instr decoded for the controller
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  f3,
  output logic [6:0]  f7
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;

  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic [31:0] target;

  // Word-align the redirect target.
  assign target = redirect_pc & ~32'h0000_0003;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;

    // Slot empties unless a load below fills it; a redirect flushes even
    // under stall. id_pc is deliberately left alone when emptying.
    if (redirect || !stall) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
        req_d   = 1'b1;
      end

      FETCH: begin
        if (redirect) begin
          pc_d = target;
          if (!imem_rvalid) begin
            // Request still in flight: wait for it and drop it.
            state_d = DISCARD;
            req_d   = 1'b0;
          end
          // With rvalid in the same cycle the response is simply dropped
          // and the next request goes out from the target directly.
        end else if (imem_rvalid) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
            req_d        = 1'b0;
          end else begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          skid_valid_d = 1'b0;
          pc_d         = target;
          state_d      = FETCH;
          req_d        = 1'b1;
        end else if (!stall) begin
          id_valid_d   = skid_valid_q;
          id_instr_d   = skid_instr_q;
          id_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
          req_d        = 1'b1;
        end
      end

      DISCARD: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end

      default: begin
        state_d = BOOT;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign opcode    = id_instr_q[6:0];
  assign f3        = id_instr_q[14:12];
  assign f7        = id_instr_q[31:25];

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;

  int checks = 0;
  int failures = 0;

  // memory model state
  int          lat = 1;
  bit          fixed_en = 1'b0;
  logic        spur = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] maddr = '0;
  int          addr_glitch = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } id_t;

  logic [31:0] issued_q[$];
  logic [31:0] exp_addr_q[$];
  id_t         exp_id_q[$];

  assign imem_rvalid = mem_rvalid | spur;
  assign imem_rdata  = spur ? 32'hDEAD_BEEF : mem_rdata;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .opcode     (opcode),
    .f3         (f3),
    .f7         (f7)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return fixed_en ? 32'h00A0_0093 : (a ^ 32'h1357_0033);
  endfunction

  // Memory: one request at a time, response `lat` cycles after issue.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      busy       = 1'b0;
      mem_rvalid = 1'b0;
      cnt        = 0;
    end else begin
      if (mem_rvalid) begin
        mem_rvalid = 1'b0;
        busy       = 1'b0;
      end
      if (busy && imem_req && imem_addr !== maddr) addr_glitch++;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word(maddr);
        end
      end else if (imem_req) begin
        busy  = 1'b1;
        maddr = imem_addr;
        cnt   = lat;
        issued_q.push_back(imem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    spur     = 1'b0;
    tick();
    tick();
    issued_q.delete();
    exp_addr_q.delete();
    exp_id_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", id_instr, NOP); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
    checks++; if (opcode !== 7'h13 || f3 !== 3'h0 || f7 !== 7'h0) begin failures++; $display("FAIL rst_fields got=%h/%h/%h exp=13/0/0", opcode, f3, f7); end
    issued_q.delete();
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", imem_req); end
    tick();
    // request visible after the first edge, captured by memory on the second
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    exp_addr_q.push_back(32'h0);
    tick();
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL reset_addr got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_basic();
    int n;
    id_t x;
    do_reset();
    fixed_en = 1'b1;
    lat = 1;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
    exp_id_q.push_back('{32'h00A0_0093, 32'h0});
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    x = exp_id_q.pop_front();
    checks++; if (n != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", n); end
    checks++; if (id_valid !== 1'b1 || id_instr !== x.instr || id_pc !== x.pc) begin failures++; $display("FAIL basic_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_instr, id_pc, x.instr, x.pc); end
    checks++; if (opcode !== 7'h13 || f3 !== 3'h0) begin failures++; $display("FAIL basic_fields got=%h/%h exp=13/0", opcode, f3); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0) begin failures++; $display("FAIL basic_empty got=%b/%h/%h exp=0/%h/0", id_valid, id_instr, id_pc, NOP); end
    n = 0;
    while (issued_q.size() < 3 && n < 20) begin tick(); n++; end
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL basic_addr got=%h exp=%h", a, e); end
    end
    fixed_en = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    id_t x;
    do_reset();
    lat = 1;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8); exp_addr_q.push_back(32'hC);
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 20) begin tick(); n++; end
    x = '{word(32'h4), 32'h4};
    checks++; if (id_valid !== 1'b1 || id_pc !== x.pc) begin failures++; $display("FAIL stall_pre got=%b/%h exp=1/%h", id_valid, id_pc, x.pc); end
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL stall_wait got=%b/%h exp=1/%h", imem_req, id_pc, x.pc); end
    tick();
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL stall_hold got=%b/%b/%h/%h exp=0/1/%h/%h", imem_req, id_valid, id_pc, id_instr, x.pc, x.instr); end
    spur = 1'b1;
    tick();
    spur = 1'b0;
    checks++; if (imem_req !== 1'b0 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL stall_spur got=%b/%h/%h exp=0/%h/%h", imem_req, id_pc, id_instr, x.pc, x.instr); end
    stall = 1'b0;
    exp_id_q.push_back('{word(32'h8), 32'h8});
    tick();
    x = exp_id_q.pop_front();
    checks++; if (id_valid !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL stall_release got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, x.pc, x.instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL stall_next got=%b/%h exp=1/c", imem_req, imem_addr); end
    n = 0;
    while (issued_q.size() < 4 && n < 20) begin tick(); n++; end
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL stall_addr got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_redirect_discard();
    int n;
    id_t x;
    do_reset();
    lat = 2;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h100);
    tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP) begin failures++; $display("FAIL disc_enter got=%b/%b/%h exp=0/0/%h", imem_req, id_valid, id_instr, NOP); end
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 2 || imem_addr !== 32'h100) begin failures++; $display("FAIL disc_refetch got=%0d/%h exp=2/100", n, imem_addr); end
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin failures++; $display("FAIL disc_drop got=%b/%h exp=0/%h", id_valid, id_instr, NOP); end
    exp_id_q.push_back('{word(32'h100), 32'h100});
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    x = exp_id_q.pop_front();
    checks++; if (id_valid !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL disc_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, x.pc, x.instr); end
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL disc_addr got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_redirect_in_discard();
    int n;
    id_t x;
    do_reset();
    lat = 3;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h208);
    tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_pc = 32'h20B;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL disc2_hold got=%b/%b exp=0/0", imem_req, id_valid); end
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (imem_addr !== 32'h208) begin failures++; $display("FAIL disc2_addr got=%h exp=208", imem_addr); end
    exp_id_q.push_back('{word(32'h208), 32'h208});
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    x = exp_id_q.pop_front();
    checks++; if (id_valid !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL disc2_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, x.pc, x.instr); end
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL disc2_seq got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_redirect_same();
    int n;
    id_t x;
    do_reset();
    lat = 1;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h400);
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    stall = 1'b1;
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== word(32'h0)) begin failures++; $display("FAIL same_stallhold got=%b/%h/%h exp=1/0/%h", id_valid, id_pc, id_instr, word(32'h0)); end
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin failures++; $display("FAIL same_flush got=%b/%h exp=0/%h", id_valid, id_instr, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL same_req got=%b/%h exp=1/400", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL same_nodisc got=%b/%h exp=1/400", imem_req, imem_addr); end
    exp_id_q.push_back('{word(32'h400), 32'h400});
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    x = exp_id_q.pop_front();
    checks++; if (id_valid !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL same_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, x.pc, x.instr); end
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL same_addr got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_wrap();
    int n;
    id_t x;
    do_reset();
    lat = 1;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    exp_id_q.push_back('{word(32'hFFFF_FFFC), 32'hFFFF_FFFC});
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    x = exp_id_q.pop_front();
    checks++; if (id_valid !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL wrap_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, x.pc, x.instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); end
    n = 0;
    while (issued_q.size() < 3 && n < 20) begin tick(); n++; end
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    id_t x;
    do_reset();
    lat = 1;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h0);
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    stall = 1'b1;
    lat = 3;
    tick();
    checks++; if (id_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL mid_pre got=%b/%b/%h exp=1/1/4", id_valid, imem_req, imem_addr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_async got=%b/%b/%h/%h/%h exp=0/0/%h/0/0", imem_req, id_valid, id_instr, id_pc, imem_addr, NOP); end
    stall = 1'b0;
    lat = 1;
    tick();
    rst = 1'b0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_boot got=%b/%b/%h exp=0/1/0", id_valid, imem_req, imem_addr); end
    exp_id_q.push_back('{word(32'h0), 32'h0});
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin tick(); n++; end
    x = exp_id_q.pop_front();
    checks++; if (id_valid !== 1'b1 || id_pc !== x.pc || id_instr !== x.instr) begin failures++; $display("FAIL mid_id got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, x.pc, x.instr); end
    while (exp_addr_q.size() > 0) begin
      logic [31:0] e, a;
      e = exp_addr_q.pop_front();
      checks++;
      a = (issued_q.size() > 0) ? issued_q.pop_front() : 32'hXXXX_XXXX;
      if (a !== e) begin failures++; $display("FAIL mid_addr got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (addr_glitch !== 0) begin failures++; $display("FAIL addr_stable got=%0d changes exp=0", addr_glitch); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_discard();
    test_redirect_in_discard();
    test_redirect_same();
    test_wrap();
    test_reset_mid();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
